// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// default transmitter timeout and the round-robin pointer step.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [15:0] TMO_CYC_DEFAULT = 16'd50000;

  // Channel index following cur, wrapping at n_ch.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input int unsigned n_ch);
    return ((32'(cur) + 32'd1) >= n_ch) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Channel request and UART transmitter signals of the scheduler.
// master = scheduler side, slave = channel sources plus transmitter.
interface uart_tx_sched_if #(
  parameter int N_CH = 4
);
  logic [N_CH*8-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH-1:0]   ch_last;
  logic [N_CH-1:0]   ch_ready;
  logic              tx_busy;
  logic [7:0]        driver_tx_data;
  logic              driver_tx_data_valid;
  logic [2:0]        grant_ch;
  logic              sched_busy;
  logic              err_tmo;

  modport master (
    input  ch_data, ch_valid, ch_last, tx_busy,
    output ch_ready, driver_tx_data, driver_tx_data_valid, grant_ch, sched_busy, err_tmo
  );

  modport slave (
    output ch_data, ch_valid, ch_last, tx_busy,
    input  ch_ready, driver_tx_data, driver_tx_data_valid, grant_ch, sched_busy, err_tmo
  );
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin search: first requesting channel at or after ptr.
module uart_rr_arb #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      grant,
  output logic            any_req
);

  always_comb begin
    int   idx;
    logic hit;
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      hit = 1'b0;
      for (int j = 0; j < N_CH; j++) begin
        if (j == idx) hit = req[j];
      end
      if (hit && !any_req) begin
        any_req = 1'b1;
        grant   = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locked byte scheduler feeding one UART transmitter.
// Optional transmitter-start timeout: define UART_TX_SCHED_TMO_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int          U_DLY   = 1,
  parameter int          N_CH    = 4,
  parameter logic [15:0] TMO_CYC = TMO_CYC_DEFAULT
) (
  input logic             clk_sys,
  input logic             rst,
  uart_tx_sched_if.master bus
);

  if (N_CH < 2 || N_CH > 8 || U_DLY < 0 || TMO_CYC == 16'd0) begin : g_bad_cfg
    $error("uart_tx_sched: unsupported parameter set");
  end

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [2:0]      grant_ch;
  logic [2:0]      arb_grant;
  logic            any_req;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            last_q;
  logic            err_q;
  logic            tmo_hit;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic [N_CH-1:0] ready;

  uart_rr_arb #(.N_CH(N_CH)) u_arb (
    .req     (bus.ch_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  // Mux the owner channel's inputs and decode its ready from registered state.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    ready     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_ch == 3'(i)) begin
        sel_valid = bus.ch_valid[i];
        sel_last  = bus.ch_last[i];
        sel_data  = bus.ch_data[8*i +: 8];
        ready[i]  = (state == ST_ISSUE);
      end
    end
  end

`ifdef UART_TX_SCHED_TMO_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                        tmo_cnt <= '0;
    else if (state != ST_WAIT_BUSY) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (tmo_cnt == TMO_CYC);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_ch <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tx_valid <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.ch_valid) state <= ST_ARB;
        end
        ST_ARB: begin
          if (any_req) begin
            grant_ch <= arb_grant;
            state    <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Owner keeps the lock while its source stalls.
          if (sel_valid) begin
            tx_data  <= sel_data;
            last_q   <= sel_last;
            tx_valid <= 1'b1;
            state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            err_q  <= 1'b1;
            rr_ptr <= next_ch(grant_ch, N_CH);
            state  <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              rr_ptr <= next_ch(grant_ch, N_CH);
              state  <= ST_ARB;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ch_ready             = ready;
  assign bus.driver_tx_data       = tx_data;
  assign bus.driver_tx_data_valid = tx_valid;
  assign bus.grant_ch             = grant_ch;
  assign bus.sched_busy           = (state != ST_IDLE);
  assign bus.err_tmo              = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: channel byte sources, a UART busy model
// and a strobe monitor that pops expected {channel, byte} in issue order.
module tb_uart_tx_sched;

  localparam int N_CH = 4;
`ifdef UART_TX_SCHED_TMO_EN
  localparam logic [15:0] TMO = 16'd100;
`else
  localparam logic [15:0] TMO = 16'd50000;
`endif

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       last;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks     = 0;
  int passed     = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int tmo_cnt    = 0;
  int tmo_cyc    = 0;
  int cyc        = 0;
  int busy_len   = 5;
  int dly_cnt    = 0;
  int busy_cnt   = 0;
  bit model_en   = 1'b1;

  item_t           ch_q[N_CH][$];
  item_t           exp_q[$];
  logic [N_CH-1:0] hs_prev = '0;

  uart_tx_sched_if #(.N_CH(N_CH)) bus ();

  uart_tx_sched #(.U_DLY(1), .N_CH(N_CH), .TMO_CYC(TMO)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Environment: strobe monitor, transmitter busy model, channel byte sources.
  initial begin
    item_t e;
    bus.ch_data  = '0;
    bus.ch_valid = '0;
    bus.ch_last  = '0;
    bus.tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.err_tmo === 1'b1) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      if (bus.driver_tx_data_valid === 1'b1) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        checks++;
        if (bus.tx_busy !== 1'b0) $display("FAIL strobe_while_busy: tx_busy=%b required 0", bus.tx_busy);
        else passed++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_strobe: ch=%0d data=%h, required no strobe", bus.grant_ch, bus.driver_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.driver_tx_data !== e.data || bus.grant_ch !== e.ch)
            $display("FAIL issue_order: ch=%0d data=%h required ch=%0d data=%h",
                     bus.grant_ch, bus.driver_tx_data, e.ch, e.data);
          else passed++;
        end
      end
      if (rst) begin
        bus.tx_busy = 1'b0;
        dly_cnt     = 0;
        busy_cnt    = 0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end else if (dly_cnt > 0) begin
          dly_cnt--;
          if (dly_cnt == 0) begin
            bus.tx_busy = 1'b1;
            busy_cnt    = busy_len;
          end
        end
        if (bus.driver_tx_data_valid === 1'b1 && model_en) dly_cnt = 3;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (hs_prev[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
        if (ch_q[i].size() > 0) begin
          bus.ch_valid[i]       = 1'b1;
          bus.ch_data[8*i +: 8] = ch_q[i][0].data;
          bus.ch_last[i]        = ch_q[i][0].last;
        end else begin
          bus.ch_valid[i]       = 1'b0;
          bus.ch_data[8*i +: 8] = 8'h00;
          bus.ch_last[i]        = 1'b0;
        end
        hs_prev[i] = !rst && bus.ch_valid[i] && (bus.ch_ready[i] === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input int ch, input logic [7:0] d, input logic l);
    item_t it;
    it.ch   = 3'(ch);
    it.data = d;
    it.last = l;
    ch_q[ch].push_back(it);
  endtask

  task automatic expect_byte(input int ch, input logic [7:0] d);
    item_t it;
    it.ch   = 3'(ch);
    it.data = d;
    it.last = 1'b0;
    exp_q.push_back(it);
  endtask

  task automatic wait_strobes(input int target, input string name);
    int n = 0;
    while (strobe_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (strobe_cnt < target) $display("FAIL %s: strobes=%0d required %0d", name, strobe_cnt, target);
    else passed++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.sched_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.sched_busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL %s: sched_busy=%b pending=%0d required 0/0", name, bus.sched_busy, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.driver_tx_data, bus.driver_tx_data_valid, bus.grant_ch, bus.sched_busy, bus.err_tmo, bus.ch_ready} !== '0)
      $display("FAIL reset_outputs: data=%h v=%b g=%0d busy=%b err=%b rdy=%b required all 0",
               bus.driver_tx_data, bus.driver_tx_data_valid, bus.grant_ch, bus.sched_busy, bus.err_tmo, bus.ch_ready);
    else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sched_busy !== 1'b0 || strobe_cnt != 0)
      $display("FAIL idle_after_reset: sched_busy=%b strobes=%0d required 0/0", bus.sched_busy, strobe_cnt);
    else passed++;
  endtask

  task automatic test_single_byte;
    int base = strobe_cnt;
    int n    = 0;
    busy_len = 80;
    push_byte(0, 8'hA5, 1'b1);
    expect_byte(0, 8'hA5);
    wait_strobes(base + 1, "single_strobe");
    while (bus.tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (bus.tx_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus.tx_busy !== 1'b0 || bus.sched_busy !== 1'b1)
      $display("FAIL busy_order: tx_busy=%b sched_busy=%b required 0/1", bus.tx_busy, bus.sched_busy);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sched_busy !== 1'b0) $display("FAIL sched_busy_fall: sched_busy=%b required 0", bus.sched_busy);
    else passed++;
    checks++;
    if (strobe_cnt != base + 1 || bus.driver_tx_data !== 8'hA5)
      $display("FAIL single_hold: strobes=%0d data=%h required %0d/a5", strobe_cnt, bus.driver_tx_data, base + 1);
    else passed++;
    busy_len = 5;
  endtask

  task automatic test_round_robin;
    int base = strobe_cnt;
    push_byte(1, 8'h11, 1'b1);
    push_byte(2, 8'h22, 1'b1);
    expect_byte(1, 8'h11);
    expect_byte(2, 8'h22);
    wait_strobes(base + 2, "rr_strobes");
    wait_idle("rr_idle");
  endtask

  task automatic test_wrap;
    int base = strobe_cnt;
    push_byte(3, 8'h33, 1'b1);
    expect_byte(3, 8'h33);
    wait_strobes(base + 1, "wrap_strobe");
    wait_idle("wrap_idle");
  endtask

  task automatic test_packet_lock;
    int base = strobe_cnt;
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b0);
    push_byte(0, 8'h03, 1'b1);
    push_byte(3, 8'h04, 1'b1);
    expect_byte(0, 8'h01);
    expect_byte(0, 8'h02);
    expect_byte(0, 8'h03);
    expect_byte(3, 8'h04);
    wait_strobes(base + 4, "lock_strobes");
    wait_idle("lock_idle");
  endtask

  task automatic test_stall;
    int base     = strobe_cnt;
    int n        = 0;
    int bad_grnt = 0;
    int bad_rdy  = 0;
    int held;
    expect_byte(2, 8'h31);
    expect_byte(2, 8'h32);
    expect_byte(1, 8'h41);
    push_byte(2, 8'h31, 1'b0);
    wait_strobes(base + 1, "stall_first");
    push_byte(1, 8'h41, 1'b1);
    while (bus.ch_ready[2] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    held = strobe_cnt;
    repeat (20) begin
      @(negedge clk);
      if (bus.grant_ch !== 3'd2) bad_grnt++;
      if (bus.ch_ready !== 4'b0100) bad_rdy++;
    end
    checks++;
    if (strobe_cnt != held || bad_grnt != 0)
      $display("FAIL stall_hold: strobes=%0d grant_errs=%0d required %0d/0", strobe_cnt, bad_grnt, held);
    else passed++;
    checks++;
    if (bad_rdy != 0) $display("FAIL stall_ready: ready_errs=%0d required 0", bad_rdy);
    else passed++;
    push_byte(2, 8'h32, 1'b1);
    wait_strobes(base + 3, "stall_resume");
    wait_idle("stall_idle");
  endtask

  task automatic test_reset_mid_packet;
    int base = strobe_cnt;
    int n    = 0;
    push_byte(0, 8'h51, 1'b1);
    expect_byte(0, 8'h51);
    wait_strobes(base + 1, "pre_rst_ch0");
    wait_idle("pre_rst_idle");
    push_byte(1, 8'h61, 1'b0);
    push_byte(1, 8'h62, 1'b1);
    expect_byte(1, 8'h61);
    wait_strobes(base + 2, "pre_rst_ch1");
    while (bus.tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N_CH; i++) ch_q[i].delete();
    @(negedge clk);
    checks++;
    if ({bus.driver_tx_data, bus.driver_tx_data_valid, bus.grant_ch, bus.sched_busy, bus.err_tmo, bus.ch_ready} !== '0)
      $display("FAIL mid_reset_outputs: data=%h v=%b g=%0d busy=%b err=%b rdy=%b required all 0",
               bus.driver_tx_data, bus.driver_tx_data_valid, bus.grant_ch, bus.sched_busy, bus.err_tmo, bus.ch_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_byte(0, 8'h71, 1'b1);
    push_byte(1, 8'h72, 1'b1);
    expect_byte(0, 8'h71);
    expect_byte(1, 8'h72);
    wait_strobes(base + 4, "post_rst_strobes");
    wait_idle("post_rst_idle");
  endtask

`ifdef UART_TX_SCHED_TMO_EN
  task automatic test_timeout;
    int base = strobe_cnt;
    int n    = 0;
    model_en = 1'b0;
    push_byte(2, 8'h81, 1'b1);
    expect_byte(2, 8'h81);
    wait_strobes(base + 1, "tmo_strobe");
    while (tmo_cnt == 0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (tmo_cnt == 0 || tmo_cyc - strobe_cyc != 101)
      $display("FAIL tmo_latency: pulses=%0d delay=%0d required >=1/101", tmo_cnt, tmo_cyc - strobe_cyc);
    else passed++;
    checks++;
    if (bus.sched_busy !== 1'b0) $display("FAIL tmo_idle: sched_busy=%b required 0", bus.sched_busy);
    else passed++;
    repeat (10) @(negedge clk);
    checks++;
    if (tmo_cnt != 1) $display("FAIL tmo_single: pulses=%0d required 1", tmo_cnt);
    else passed++;
    model_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_wrap();
    test_packet_lock();
    test_stall();
    test_reset_mid_packet();
`ifdef UART_TX_SCHED_TMO_EN
    test_timeout();
`else
    checks++;
    if (tmo_cnt != 0) $display("FAIL tmo_disabled: pulses=%0d required 0", tmo_cnt);
    else passed++;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
